mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: cycles to wait for mem_ack before a timeout; 0 disables the timeout.
REQ-002 Port clk, in, 1: the single clock; all state changes on its rising edge.
REQ-003 Port reset, in, 1: asynchronous, active-high reset.
REQ-004 Port req_valid, in, 1: the CPU presents a load/store request.
REQ-005 Port req_ready, out, 1: the unit accepts a request this cycle.
REQ-006 Port req_op, in, 3: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
REQ-007 Port req_addr, in, 32: byte address.
REQ-008 Port req_wdata, in, 32: store data, right-justified.
REQ-009 Port mem_en, out, 1: data-memory access active.
REQ-010 Port mem_we, out, 4: byte write enables; bit i covers bits [8i+7:8i].
REQ-011 Port mem_addr, out, 32: word address, {req_addr[31:2], 2'b00}.
REQ-012 Port mem_wdata, out, 32: lane-replicated store data.
REQ-013 Port mem_ack, in, 1: the memory completes the access; mem_rdata is valid in the same cycle.
REQ-014 Port mem_rdata, in, 32: read word.
REQ-015 Port rsp_valid, out, 1: one-cycle completion pulse.
REQ-016 Port rsp_data, out, 32: extended load result; 0 for stores and errors.
REQ-017 Port rsp_exc, out, 2: 0 OK, 1 misaligned, 2 timeout.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS and RESP. req_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, req_valid SHALL be accepted on the same edge.
REQ-020 Misalignment SHALL be defined as: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0.
REQ-021 Misaligned request: the unit SHALL go IDLE->RESP with rsp_exc=1 and rsp_data=0; no memory access shall occur (mem_en stays 0).
REQ-022 Aligned request: the unit SHALL latch op, addr[1:0], mem_addr, mem_we and mem_wdata, then enter ACCESS. mem_en=1 from the next cycle.
REQ-023 All mem_* outputs SHALL hold stable throughout ACCESS until mem_ack.
REQ-024 mem_we for loads SHALL be 0000.
REQ-025 mem_we for stores SHALL be: SW 1111; SH 0011 if addr[1]=0, else 1100; SB 0001 shifted left by addr[1:0].
REQ-026 mem_wdata SHALL be: SW the data unchanged; SH {2{wdata[15:0]}}; SB {4{wdata[7:0]}}.
REQ-027 On mem_ack in ACCESS, the unit SHALL register rsp_data and go to RESP with rsp_exc=0.
REQ-028 Load extraction on mem_ack:
- byte = rdata[8*off+7:8*off]; LB sign-extends, LBU zero-extends.
- half = rdata[31:16] if off[1]=1, else rdata[15:0]; LH sign-extends, LHU zero-extends.
- LW passes the word unchanged.
REQ-029 Timeout: a counter SHALL clear on entering ACCESS and increment each ACCESS cycle without ack. When it reaches TIMEOUT_CYCLES without ack, the unit SHALL drop mem_en and go to RESP with rsp_exc=2 and rsp_data=0.
REQ-030 If mem_ack arrives in the same cycle the timeout would fire, the ack SHALL win.
REQ-031 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE. The next request can be accepted in the cycle after RESP.
REQ-032 mem_ack outside ACCESS SHALL be ignored.
REQ-033 Latency: accept at cycle 0, mem_en from cycle 1; ack at cycle k gives rsp_valid at cycle k+1. A misaligned request gives rsp_valid at cycle 1.

Reset
REQ-034 reset SHALL immediately force state IDLE and clear the counter. All outputs SHALL go to 0 except req_ready, which goes to 1.
REQ-035 Reset mid-ACCESS SHALL abandon the access. A late mem_ack after reset SHALL produce no response.

Structure
REQ-036 A shared package SHALL hold the op encodings, rsp_exc codes and FSM state encoding.
REQ-037 Load extraction and extension SHALL be a combinational sub-module, mem_load_ext (inputs: op, off, rdata; output: 32-bit result).

Verification
REQ-038 LB, addr 0x0000_0103, rdata 0x80FF_1234, ack after 2 cycles -> rsp_data 0xFFFF_FF80, rsp_exc 0, rsp_valid exactly one cycle.
REQ-039 SH, addr 0x0000_0012, wdata 0x0000_ABCD -> mem_we 1100, mem_wdata 0xABCD_ABCD, mem_addr 0x0000_0010; ack -> rsp_data 0.
REQ-040 LW, addr 0x0000_0006 -> rsp_valid at cycle 1 with rsp_exc 1; mem_en never asserted.
REQ-041 LHU, addr 0x0000_0000, no ack, TIMEOUT_CYCLES 16 -> mem_en high 16 cycles, then rsp_exc 2, rsp_data 0.
REQ-042 Reset pulse during ACCESS, then mem_ack -> no rsp_valid; req_ready is 1 right after reset; a subsequent SB completes normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and request-decode helpers for the load/store access unit.
package mem_access_unit_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [1:0] EXC_OK        = 2'd0;
  localparam logic [1:0] EXC_MISALIGN  = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT   = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_LW, OP_SW:         return off != 2'b00;
      OP_LH, OP_LHU, OP_SH: return off[0];
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_we(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_SW:   return 4'b1111;
      OP_SH:   return off[1] ? 4'b1100 : 4'b0011;
      OP_SB:   return 4'b0001 << off;
      default: return 4'b0000;
    endcase
  endfunction

  // Stores replicate the data across lanes so the byte enables alone pick the target.
  function automatic logic [31:0] store_wdata(input logic [2:0] op, input logic [31:0] wdata);
    case (op)
      OP_SW:   return wdata;
      OP_SH:   return {2{wdata[15:0]}};
      OP_SB:   return {4{wdata[7:0]}};
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Combinational lane selection and sign/zero extension of a loaded word.
module mem_load_ext
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shifted = rdata >> {off, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    // NOTE: default assignment first so no path leaves result unassigned (no latch).
    result = 32'h0;
    case (op)
      OP_LW:   result = rdata;
      OP_LH:   result = {{16{w_half[15]}}, w_half};
      OP_LHU:  result = {16'h0, w_half};
      OP_LB:   result = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  result = {24'h0, w_byte};
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: alignment check, lane steering, ack timeout.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_exc
);

  localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;

  logic [1:0]  r_state;
  logic [2:0]  r_op;
  logic [1:0]  r_off;
  logic [31:0] r_addr;
  logic [3:0]  r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_cnt;
  logic [31:0] r_rsp_data;
  logic [1:0]  r_rsp_exc;
  logic [31:0] w_load;
  logic        w_timeout;

  mem_load_ext u_load_ext (
    .op     (r_op),
    .off    (r_off),
    .rdata  (mem_rdata),
    .result (w_load)
  );

  // The last ACCESS cycle without ack is the one where the count would reach the limit.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_LW;
      r_off      <= 2'b00;
      r_addr     <= 32'h0;
      r_we       <= 4'h0;
      r_wdata    <= 32'h0;
      r_cnt      <= 32'h0;
      r_rsp_data <= 32'h0;
      r_rsp_exc  <= EXC_OK;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            if (is_misaligned(req_op, req_addr[1:0])) begin
              r_state    <= ST_RESP;
              r_rsp_exc  <= EXC_MISALIGN;
              r_rsp_data <= 32'h0;
            end else begin
              r_state <= ST_ACCESS;
              r_op    <= req_op;
              r_off   <= req_addr[1:0];
              r_addr  <= {req_addr[31:2], 2'b00};
              r_we    <= store_we(req_op, req_addr[1:0]);
              r_wdata <= store_wdata(req_op, req_wdata);
              r_cnt   <= 32'h0;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            r_state    <= ST_RESP;
            r_rsp_exc  <= EXC_OK;
            r_rsp_data <= is_store(r_op) ? 32'h0 : w_load;
          end else if (w_timeout) begin
            r_state    <= ST_RESP;
            r_rsp_exc  <= EXC_TIMEOUT;
            r_rsp_data <= 32'h0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_RESP: begin
          r_state    <= ST_IDLE;
          r_rsp_data <= 32'h0;
          r_rsp_exc  <= EXC_OK;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign mem_en    = (r_state == ST_ACCESS);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_exc   = r_rsp_exc;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, timeout and reset abort.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_exc;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_exc   (rsp_exc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one accept edge; on return the unit is in cycle 1.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  int en_count;

  initial begin
    // Reset state
    #3;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_exc", 32'(rsp_exc), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // LB 0x103, ack in cycle 2
    issue(3'd3, 32'h0000_0103, 32'h0);
    check("lb_c1_mem_en", 32'(mem_en), 32'd1);
    check("lb_c1_ready", 32'(req_ready), 32'd0);
    check("lb_mem_we", 32'(mem_we), 32'd0);
    check("lb_mem_addr", mem_addr, 32'h0000_0100);
    check("lb_c1_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    check("lb_c2_mem_en", 32'(mem_en), 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'h80FF_1234;
    tick();
    mem_ack = 1'b0;
    check("lb_rsp_valid", 32'(rsp_valid), 32'd1);
    check("lb_rsp_data", rsp_data, 32'hFFFF_FF80);
    check("lb_rsp_exc", 32'(rsp_exc), 32'd0);
    check("lb_resp_mem_en", 32'(mem_en), 32'd0);
    tick();
    check("lb_pulse_end", 32'(rsp_valid), 32'd0);
    check("lb_ready_again", 32'(req_ready), 32'd1);

    // SH 0x12, ack in cycle 1
    issue(3'd6, 32'h0000_0012, 32'h0000_ABCD);
    check("sh_mem_en", 32'(mem_en), 32'd1);
    check("sh_mem_we", 32'(mem_we), 32'hC);
    check("sh_mem_wdata", mem_wdata, 32'hABCD_ABCD);
    check("sh_mem_addr", mem_addr, 32'h0000_0010);
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    check("sh_rsp_valid", 32'(rsp_valid), 32'd1);
    check("sh_rsp_data", rsp_data, 32'h0);
    check("sh_rsp_exc", 32'(rsp_exc), 32'd0);
    tick();

    // LW 0x6 misaligned
    issue(3'd0, 32'h0000_0006, 32'h0);
    check("mis_rsp_valid", 32'(rsp_valid), 32'd1);
    check("mis_rsp_exc", 32'(rsp_exc), 32'd1);
    check("mis_rsp_data", rsp_data, 32'h0);
    check("mis_mem_en", 32'(mem_en), 32'd0);
    tick();
    check("mis_pulse_end", 32'(rsp_valid), 32'd0);
    check("mis_mem_en_after", 32'(mem_en), 32'd0);

    // LH 0x2, upper half sign-extended
    issue(3'd1, 32'h0000_0002, 32'h0);
    mem_ack = 1'b1;
    mem_rdata = 32'h8001_7FFF;
    tick();
    mem_ack = 1'b0;
    check("lh_rsp_data", rsp_data, 32'hFFFF_8001);
    tick();

    // LBU 0x1, zero-extended
    issue(3'd4, 32'h0000_0001, 32'h0);
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_9A00;
    tick();
    mem_ack = 1'b0;
    check("lbu_rsp_data", rsp_data, 32'h0000_009A);
    tick();

    // SW 0x8
    issue(3'd5, 32'h0000_0008, 32'h1234_5678);
    check("sw_mem_we", 32'(mem_we), 32'hF);
    check("sw_mem_wdata", mem_wdata, 32'h1234_5678);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sw_rsp_exc", 32'(rsp_exc), 32'd0);
    tick();

    // LHU 0x0, no ack: 16 cycles of mem_en then timeout
    issue(3'd2, 32'h0000_0000, 32'h0);
    en_count = 0;
    for (int i = 0; i < 16; i++) begin
      if (mem_en) en_count++;
      if (i == 15) check("to_addr_stable", mem_addr, 32'h0);
      tick();
    end
    check("to_en_cycles", 32'(en_count), 32'd16);
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_rsp_exc", 32'(rsp_exc), 32'd2);
    check("to_rsp_data", rsp_data, 32'h0);
    check("to_mem_en", 32'(mem_en), 32'd0);
    mem_ack = 1'b1;
    tick();
    check("ack_in_resp_ignored", 32'(rsp_valid), 32'd0);
    tick();
    check("ack_in_idle_ignored", 32'(rsp_valid), 32'd0);
    mem_ack = 1'b0;

    // LW 0x20, ack in the very cycle the timeout would fire
    issue(3'd0, 32'h0000_0020, 32'h0);
    for (int i = 0; i < 15; i++) tick();
    check("tie_mem_en", 32'(mem_en), 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    check("tie_rsp_valid", 32'(rsp_valid), 32'd1);
    check("tie_rsp_exc", 32'(rsp_exc), 32'd0);
    check("tie_rsp_data", rsp_data, 32'h1234_5678);
    tick();

    // Reset mid-ACCESS, then a late ack
    issue(3'd0, 32'h0000_0040, 32'h0);
    tick();
    reset = 1'b1;
    #2;
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_mem_en", 32'(mem_en), 32'd0);
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    check("late_ack_no_rsp1", 32'(rsp_valid), 32'd0);
    tick();
    check("late_ack_no_rsp2", 32'(rsp_valid), 32'd0);
    mem_ack = 1'b0;

    // SB 0x21 after reset
    issue(3'd7, 32'h0000_0021, 32'h0000_00C3);
    check("sb_mem_en", 32'(mem_en), 32'd1);
    check("sb_mem_we", 32'(mem_we), 32'h2);
    check("sb_mem_wdata", mem_wdata, 32'hC3C3_C3C3);
    check("sb_mem_addr", mem_addr, 32'h0000_0020);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sb_rsp_valid", 32'(rsp_valid), 32'd1);
    check("sb_rsp_exc", 32'(rsp_exc), 32'd0);
    check("sb_rsp_data", rsp_data, 32'h0);
    tick();
    check("sb_done_ready", 32'(req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
